// File: rtl/mux_arb_pkg.sv
// Shared definitions for the two-source mux-select arbiter: state encoding
// and the default forced-rotation limit.
package mux_arb_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_A = 2'd1;
  localparam logic [1:0] GNT_B = 2'd2;

  localparam int MAX_HOLD_DEFAULT = 4;

endpackage

// File: rtl/hold_counter.sv
// Counts consecutive cycles a grant has been held; restarts at 1 on load and
// sticks at MAX_HOLD so a long solo grant never wraps.
module hold_counter #(
  parameter int CNT_W    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = CNT_W'(1);
    end else if (inc && (count_q < CNT_W'(MAX_HOLD))) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign sat   = (count_q == CNT_W'(MAX_HOLD));

endmodule

// File: rtl/mux_sel_arbiter.sv
// Two-requester arbiter steering a downstream 2:1 mux; alternates on ties and
// forces rotation after MAX_HOLD cycles when the other side is waiting.
module mux_sel_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b,
  output logic sel,
  output logic valid
);

  logic [1:0]       state_q, state_d;
  logic             lastGntA_q, lastGntA_d;
  logic             sel_q, sel_d;
  logic             gntA_q, gntB_q, valid_q;
  logic             holdLoad, holdInc, holdSat, rotate;
  logic [CNT_W-1:0] holdCount;

  assign rotate = (holdCount >= CNT_W'(MAX_HOLD));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_a && req_b) begin
          state_d = lastGntA_q ? GNT_B : GNT_A;
        end else if (req_a) begin
          state_d = GNT_A;
        end else if (req_b) begin
          state_d = GNT_B;
        end
      end
      GNT_A: begin
        if (!req_a) begin
          state_d = req_b ? GNT_B : IDLE;
        end else if (req_b && rotate) begin
          state_d = GNT_B;
        end
      end
      GNT_B: begin
        if (!req_b) begin
          state_d = req_a ? GNT_A : IDLE;
        end else if (req_a && rotate) begin
          state_d = GNT_A;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Any change into a grant state (including a direct A<->B swap) is an entry.
  always_comb begin
    holdLoad   = (state_d != state_q) && (state_d != IDLE);
    holdInc    = (state_d == state_q) && (state_q != IDLE) && !holdSat;
    lastGntA_d = lastGntA_q;
    sel_d      = sel_q;
    if (holdLoad) begin
      lastGntA_d = (state_d == GNT_A);
      sel_d      = (state_d == GNT_A);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lastGntA_q <= 1'b0;
      sel_q      <= 1'b0;
      gntA_q     <= 1'b0;
      gntB_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      lastGntA_q <= lastGntA_d;
      sel_q      <= sel_d;
      gntA_q     <= (state_d == GNT_A);
      gntB_q     <= (state_d == GNT_B);
      valid_q    <= (state_d != IDLE);
    end
  end

  hold_counter #(
    .CNT_W    (CNT_W),
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_counter (
    .clk   (clk),
    .rst   (rst),
    .load  (holdLoad),
    .inc   (holdInc),
    .count (holdCount),
    .sat   (holdSat)
  );

  assign gnt_a = gntA_q;
  assign gnt_b = gntB_q;
  assign sel   = sel_q;
  assign valid = valid_q;

endmodule
